// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store front-end between the execute stage and the on-chip word RAM.
//
// Accepts one op at a time, checks alignment, issues one RAM request with byte enables and
// lane-replicated store data, waits for the RAM response and returns extended load data or a
// fault cause to writeback as a single-cycle pulse.
//
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   op_valid_i/op_ready_o handshake from execute (ready only while idle)
//   op_store_i           1 = store, 0 = load
//   op_size_i            00 byte, 01 half, 10 word, 11 illegal
//   op_unsigned_i        loads: 1 = zero-extend, 0 = sign-extend
//   op_addr_i            byte address
//   op_wdata_i           right-justified store data
//   resp_valid_o         one-cycle response pulse
//   resp_data_o          extended load data (0 for stores and faults)
//   resp_cause_o         00 ok, 01 misaligned/illegal, 10 access fault, 11 timeout
//   mem_req_o ... mem_wdata_o  RAM request, word-aligned address, byte enables, store data
//   mem_rdata_i, mem_rvalid_i  RAM response
//   mem_fault_i          combinational out-of-range flag, valid while mem_req_o = 1

module lsu_mem_port #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        op_valid_i,
   output logic        op_ready_o,
   input  logic        op_store_i,
   input  logic [1:0]  op_size_i,
   input  logic        op_unsigned_i,
   input  logic [31:0] op_addr_i,
   input  logic [31:0] op_wdata_i,
   output logic        resp_valid_o,
   output logic [31:0] resp_data_o,
   output logic [1:0]  resp_cause_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_rvalid_i,
   input  logic        mem_fault_i
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

   localparam logic [1:0] CauseOk       = 2'b00;
   localparam logic [1:0] CauseMisalign = 2'b01;
   localparam logic [1:0] CauseFault    = 2'b10;
   localparam logic [1:0] CauseTimeout  = 2'b11;

   localparam logic [1:0] SizeByte = 2'b00;
   localparam logic [1:0] SizeHalf = 2'b01;
   localparam logic [1:0] SizeWord = 2'b10;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StResp
   } state_e;

   // ---------------------------------------------------------------------------------------
   // Helper functions
   // ---------------------------------------------------------------------------------------

   // Illegal size or an address not aligned to the access size.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      logic bad;
      case (size)
         SizeByte: bad = 1'b0;
         SizeHalf: bad = off[0];
         SizeWord: bad = (off != 2'b00);
         default:  bad = 1'b1;
      endcase
      return bad;
   endfunction

   function automatic logic [3:0] gen_be(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] be;
      case (size)
         SizeByte: be = 4'b0001 << off;
         SizeHalf: be = 4'b0011 << {off[1], 1'b0};
         default:  be = 4'b1111;
      endcase
      return be;
   endfunction

   // Replicate the store data across all lanes so the RAM only needs the byte enables.
   function automatic logic [31:0] gen_wdata(input logic [1:0] size, input logic [31:0] wdata);
      logic [31:0] d;
      case (size)
         SizeByte: d = {4{wdata[7:0]}};
         SizeHalf: d = {2{wdata[15:0]}};
         default:  d = wdata;
      endcase
      return d;
   endfunction

   function automatic logic [31:0] extract_load(input logic [1:0]  size,
                                                input logic        uns,
                                                input logic [1:0]  off,
                                                input logic [31:0] rdata);
      logic [31:0] shifted;
      logic [31:0] d;
      shifted = rdata >> {off, 3'b000};
      case (size)
         SizeByte: d = uns ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
         SizeHalf: d = uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
         default:  d = shifted;
      endcase
      return d;
   endfunction

   // ---------------------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------------------

   state_e            state_q, state_d;
   logic              store_q, store_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       data_q, data_d;
   logic [1:0]        cause_q, cause_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [CntW-1:0]   cnt_inc;

   assign cnt_inc = cnt_q + 1'b1;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         store_q <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         data_q  <= 32'h0;
         cause_q <= CauseOk;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         store_q <= store_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         data_q  <= data_d;
         cause_q <= cause_d;
         cnt_q   <= cnt_d;
      end
   end

   // ---------------------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------------------

   always_comb begin
      state_d = state_q;
      store_d = store_q;
      size_d  = size_q;
      uns_d   = uns_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      data_d  = data_q;
      cause_d = cause_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         StIdle: begin
            if (op_valid_i) begin
               store_d = op_store_i;
               size_d  = op_size_i;
               uns_d   = op_unsigned_i;
               addr_d  = op_addr_i;
               wdata_d = op_wdata_i;
               if (is_misaligned(op_size_i, op_addr_i[1:0])) begin
                  // Rejected before the RAM ever sees it.
                  data_d  = 32'h0;
                  cause_d = CauseMisalign;
                  state_d = StResp;
               end else begin
                  state_d = StIssue;
               end
            end
         end

         StIssue: begin
            if (mem_fault_i) begin
               data_d  = 32'h0;
               cause_d = CauseFault;
               state_d = StResp;
            end else begin
               cnt_d   = '0;
               state_d = StWait;
            end
         end

         StWait: begin
            // A response on the final counted cycle still beats the timeout.
            if (mem_rvalid_i) begin
               data_d  = store_q ? 32'h0 : extract_load(size_q, uns_q, addr_q[1:0], mem_rdata_i);
               cause_d = CauseOk;
               state_d = StResp;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == CntMax) begin
                  data_d  = 32'h0;
                  cause_d = CauseTimeout;
                  state_d = StResp;
               end
            end
         end

         StResp: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // ---------------------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------------------

   // Everything is forced low while reset is asserted, even before the first clock edge has
   // loaded the reset state.
   always_comb begin
      op_ready_o   = 1'b0;
      resp_valid_o = 1'b0;
      resp_data_o  = 32'h0;
      resp_cause_o = CauseOk;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      mem_be_o     = 4'b0000;
      mem_addr_o   = 32'h0;
      mem_wdata_o  = 32'h0;

      if (rst_ni) begin
         unique case (state_q)
            StIdle: begin
               op_ready_o = 1'b1;
            end
            StIssue: begin
               mem_req_o   = 1'b1;
               mem_we_o    = store_q;
               mem_be_o    = gen_be(size_q, addr_q[1:0]);
               mem_addr_o  = {addr_q[31:2], 2'b00};
               mem_wdata_o = gen_wdata(size_q, wdata_q);
            end
            StWait: begin
            end
            StResp: begin
               resp_valid_o = 1'b1;
               resp_data_o  = data_q;
               resp_cause_o = cause_q;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_port.sv
module tb_lsu_mem_port;

   localparam int TO   = 16;
   localparam int NCyc = TO + 6;

   logic        clk;
   logic        rst_n;
   logic        op_valid;
   logic        op_ready;
   logic        op_store;
   logic [1:0]  op_size;
   logic        op_unsigned;
   logic [31:0] op_addr;
   logic [31:0] op_wdata;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic [1:0]  resp_cause;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_rvalid;
   logic        mem_fault;
   logic        fault_cfg;

   int n_checks = 0;
   int n_fail   = 0;

   lsu_mem_port #(.TIMEOUT_CYCLES(TO)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .op_valid_i   (op_valid),
      .op_ready_o   (op_ready),
      .op_store_i   (op_store),
      .op_size_i    (op_size),
      .op_unsigned_i(op_unsigned),
      .op_addr_i    (op_addr),
      .op_wdata_i   (op_wdata),
      .resp_valid_o (resp_valid),
      .resp_data_o  (resp_data),
      .resp_cause_o (resp_cause),
      .mem_req_o    (mem_req),
      .mem_we_o     (mem_we),
      .mem_be_o     (mem_be),
      .mem_addr_o   (mem_addr),
      .mem_wdata_o  (mem_wdata),
      .mem_rdata_i  (mem_rdata),
      .mem_rvalid_i (mem_rvalid),
      .mem_fault_i  (mem_fault)
   );

   // RAM range check modelled as combinational on the request.
   assign mem_fault = mem_req & fault_cfg;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // k = number of WAIT cycles before the single mem_rvalid pulse (k >= TO means none in time)
   typedef struct {
      logic        st;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        fault;
      int          k;
      logic [1:0]  cause;
      logic [31:0] data;
      logic [3:0]  be;
      logic [31:0] mwdata;
      int          rcyc;
   } vec_t;

   function automatic vec_t mk(input logic st, input logic [1:0] sz, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input logic fault, input int k,
                               input logic [1:0] cause, input logic [31:0] data,
                               input logic [3:0] be, input logic [31:0] mwdata, input int rcyc);
      vec_t v;
      v.st = st; v.sz = sz; v.uns = uns; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
      v.fault = fault; v.k = k; v.cause = cause; v.data = data; v.be = be;
      v.mwdata = mwdata; v.rcyc = rcyc;
      return v;
   endfunction

   // Reference model: derives the expected outcome from the access rules arithmetically.
   function automatic vec_t model(input vec_t v);
      vec_t   e;
      int     nbytes;
      int     bits;
      int     off;
      longint mask;
      longint val;
      longint rep;
      logic   mis;
      e      = v;
      off    = int'(v.addr[1:0]);
      mis    = (v.sz == 2'd3) || (v.sz == 2'd1 && (off % 2) != 0) || (v.sz == 2'd2 && off != 0);
      nbytes = (v.sz == 2'd3) ? 4 : (1 << v.sz);
      bits   = 8 * nbytes;
      mask   = (64'sd1 <<< bits) - 1;
      e.be   = 4'(((1 << nbytes) - 1) << off);
      rep    = 0;
      for (int i = 0; i < 4 / nbytes; i++) rep = rep | ((longint'(v.wdata) & mask) <<< (bits * i));
      e.mwdata = rep[31:0];
      if (mis) begin
         e.cause = 2'd1; e.data = 0; e.rcyc = 1;
      end else if (v.fault) begin
         e.cause = 2'd2; e.data = 0; e.rcyc = 2;
      end else if (v.k >= TO) begin
         e.cause = 2'd3; e.data = 0; e.rcyc = 2 + TO;
      end else begin
         e.cause = 2'd0;
         e.rcyc  = 3 + v.k;
         val     = (longint'(v.rdata) >>> (8 * off)) & mask;
         if (!v.uns && val[bits-1]) val = val | ~mask;
         e.data = v.st ? 32'h0 : val[31:0];
      end
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
      end
   endtask

   function automatic logic is_mis(input vec_t v);
      return (v.sz == 2'd3) || (v.sz == 2'd1 && v.addr[0]) ||
             (v.sz == 2'd2 && v.addr[1:0] != 2'b00);
   endfunction

   // Drives one op through the DUT, acting as the RAM, and compares against expectations e.
   task automatic run_op(input string name, input vec_t e);
      int          req_cnt = 0;
      int          resp_cnt = 0;
      int          resp_cyc = -1;
      int          rdy_err = 0;
      int          rv_cyc;
      logic        g_we = 1'b0;
      logic [3:0]  g_be = 4'h0;
      logic [31:0] g_addr = 32'h0;
      logic [31:0] g_wdata = 32'h0;
      logic [31:0] g_data = 32'h0;
      logic [1:0]  g_cause = 2'b00;
      logic        exp_req;
      rv_cyc = 2 + e.k;
      exp_req = !is_mis(e);
      @(negedge clk);
      check({name, ".ready_idle"}, 32'(op_ready), 32'd1);
      op_valid    = 1'b1;
      op_store    = e.st;
      op_size     = e.sz;
      op_unsigned = e.uns;
      op_addr     = e.addr;
      op_wdata    = e.wdata;
      mem_rdata   = e.rdata;
      fault_cfg   = e.fault;
      @(posedge clk);
      for (int c = 1; c <= NCyc; c++) begin
         #1;
         if (c == 1) op_valid = 1'b0;
         mem_rvalid = (c == rv_cyc);
         @(negedge clk);
         if (mem_req) begin
            req_cnt++;
            g_we = mem_we; g_be = mem_be; g_addr = mem_addr; g_wdata = mem_wdata;
         end
         if (resp_valid) begin
            resp_cnt++;
            if (resp_cyc < 0) begin
               resp_cyc = c; g_data = resp_data; g_cause = resp_cause;
            end
         end
         if (op_ready !== (c > e.rcyc)) rdy_err++;
         @(posedge clk);
      end
      #1;
      mem_rvalid = 1'b0;
      fault_cfg  = 1'b0;
      check({name, ".req_count"}, 32'(req_cnt), exp_req ? 32'd1 : 32'd0);
      if (exp_req) begin
         check({name, ".mem_addr"}, g_addr, e.addr & ~32'd3);
         check({name, ".mem_be"}, 32'(g_be), 32'(e.be));
         check({name, ".mem_we"}, 32'(g_we), 32'(e.st));
         if (e.st) check({name, ".mem_wdata"}, g_wdata, e.mwdata);
      end
      check({name, ".resp_count"}, 32'(resp_cnt), 32'd1);
      check({name, ".resp_cycle"}, 32'(resp_cyc), 32'(e.rcyc));
      check({name, ".resp_cause"}, 32'(g_cause), 32'(e.cause));
      check({name, ".resp_data"}, g_data, e.data);
      check({name, ".ready_errs"}, 32'(rdy_err), 32'd0);
   endtask

   vec_t tbl[$];
   vec_t rv;
   int   rsp_seen;

   initial begin
      // Hand-derived vectors: st sz uns addr wdata rdata fault k | cause data be mwdata rcyc
      tbl.push_back(mk(1, 0, 0, 32'h103, 32'hAB, 32'h0, 0, 1,
                       0, 32'h0, 4'b1000, 32'hABABABAB, 4));
      tbl.push_back(mk(0, 0, 0, 32'h102, 32'h0, 32'h12F45678, 0, 1,
                       0, 32'hFFFFFFF4, 4'b0100, 32'h0, 4));
      tbl.push_back(mk(0, 0, 1, 32'h102, 32'h0, 32'h12F45678, 0, 1,
                       0, 32'h000000F4, 4'b0100, 32'h0, 4));
      tbl.push_back(mk(0, 1, 0, 32'h102, 32'h0, 32'h12F45678, 0, 1,
                       0, 32'h000012F4, 4'b1100, 32'h0, 4));
      tbl.push_back(mk(0, 1, 0, 32'h101, 32'h0, 32'h12F45678, 0, 1,
                       1, 32'h0, 4'b0000, 32'h0, 1));
      tbl.push_back(mk(0, 3, 0, 32'h0, 32'h0, 32'h12F45678, 0, 1,
                       1, 32'h0, 4'b0000, 32'h0, 1));
      tbl.push_back(mk(0, 2, 0, 32'h00010000, 32'h0, 32'h55555555, 1, 1,
                       2, 32'h0, 4'b1111, 32'h0, 2));
      tbl.push_back(mk(0, 2, 0, 32'h40, 32'h0, 32'hCAFEF00D, 0, 99,
                       3, 32'h0, 4'b1111, 32'h0, 18));
      tbl.push_back(mk(0, 2, 0, 32'h40, 32'h0, 32'hDEADBEEF, 0, 15,
                       0, 32'hDEADBEEF, 4'b1111, 32'h0, 18));
      tbl.push_back(mk(1, 2, 0, 32'h8, 32'h11223344, 32'h0, 0, 1,
                       0, 32'h0, 4'b1111, 32'h11223344, 4));
      tbl.push_back(mk(1, 1, 0, 32'h2, 32'h99995AA5, 32'h0, 0, 0,
                       0, 32'h0, 4'b1100, 32'h5AA55AA5, 3));
      tbl.push_back(mk(0, 2, 0, 32'h2, 32'h0, 32'h0, 0, 1,
                       1, 32'h0, 4'b0000, 32'h0, 1));
      tbl.push_back(mk(0, 1, 0, 32'h0, 32'h0, 32'h0000807F, 0, 2,
                       0, 32'hFFFF807F, 4'b0011, 32'h0, 5));

      rst_n = 1'b0; op_valid = 1'b0; op_store = 1'b0; op_size = 2'b00; op_unsigned = 1'b0;
      op_addr = 32'h0; op_wdata = 32'h0; mem_rdata = 32'h0; mem_rvalid = 1'b0; fault_cfg = 1'b0;

      // Outputs stay low throughout reset.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst.op_ready", 32'(op_ready), 32'd0);
      check("rst.resp_valid", 32'(resp_valid), 32'd0);
      check("rst.mem_req", 32'(mem_req), 32'd0);
      check("rst.mem_be", 32'(mem_be), 32'd0);
      check("rst.mem_wdata", mem_wdata, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst.ready_after", 32'(op_ready), 32'd1);

      foreach (tbl[i]) run_op($sformatf("tbl%0d", i), tbl[i]);

      // Reset while waiting on the RAM; the late response must be dropped.
      @(negedge clk);
      op_valid = 1'b1; op_store = 1'b0; op_size = 2'd2; op_unsigned = 1'b0; op_addr = 32'h0;
      mem_rdata = 32'h13572468;
      @(posedge clk);
      #1 op_valid = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      check("midrst.ready_low", 32'(op_ready), 32'd0);
      check("midrst.resp_low", 32'(resp_valid), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      mem_rvalid = 1'b1;
      rsp_seen = 0;
      @(negedge clk);
      check("midrst.ready_after", 32'(op_ready), 32'd1);
      if (resp_valid) rsp_seen++;
      @(posedge clk);
      #1 mem_rvalid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (resp_valid) rsp_seen++;
      end
      check("midrst.no_resp", 32'(rsp_seen), 32'd0);
      @(posedge clk);
      #1;
      run_op("midrst.next", mk(0, 2, 0, 32'h0, 32'h0, 32'h2468ACE0, 0, 1,
                               0, 32'h2468ACE0, 4'b1111, 32'h0, 4));

      // Randomized ops against the reference model.
      for (int n = 0; n < 120; n++) begin
         int r;
         rv.st    = 1'($urandom_range(0, 1));
         rv.sz    = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         rv.uns   = 1'($urandom_range(0, 1));
         rv.addr  = $urandom & 32'h0003FFFF;
         if ($urandom_range(0, 3) != 0) begin
            if (rv.sz == 2'd1) rv.addr[0] = 1'b0;
            if (rv.sz == 2'd2) rv.addr[1:0] = 2'b00;
         end
         rv.wdata = $urandom;
         rv.rdata = $urandom;
         rv.fault = ($urandom_range(0, 7) == 0);
         r        = int'($urandom_range(0, 9));
         rv.k     = (r < 7) ? (r % 4) : int'($urandom_range(TO - 2, TO + 1));
         run_op($sformatf("rnd%0d", n), model(rv));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
